placement_cost_eval: RTL and testbench



---
 rtl/placement_cost_eval.sv | 132 +++++++++++++
 tb/tb_placement_cost_eval.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/placement_cost_eval.sv
// Start/done wirelength evaluator: walks an external edge list, fetches both endpoint
// positions, and accumulates Manhattan cost, k-hop cost, max edge length and edge count.
module placement_cost_eval #(
  parameter int DW       = 32,
  parameter int EDGE_AW  = 10,
  parameter int NODE_AW  = 7,
  parameter int HOP_LOG2 = 1,
  parameter int GRID_N   = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [EDGE_AW-1:0] n_edge,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               reE,
  output logic [EDGE_AW-1:0] addrE,
  input  logic [DW-1:0]      ea,
  input  logic [DW-1:0]      eb,
  output logic               reP,
  output logic [NODE_AW-1:0] addrP,
  input  logic [DW-1:0]      posX,
  input  logic [DW-1:0]      posY,
  output logic [DW-1:0]      sum,
  output logic [DW-1:0]      sum_hop,
  output logic [DW-1:0]      max_len,
  output logic [EDGE_AW-1:0] edges_done
);

  localparam int HOP = 1 << HOP_LOG2;

  typedef enum logic [3:0] {
    IDLE, RD_E, W_E, RD_A, W_A, RD_B, W_B, DIFF, ACC, FIN
  } state_t;

  state_t state, next;

  logic [EDGE_AW-1:0] n_lat, i_nxt;
  logic [NODE_AW-1:0] eb_id;
  logic [DW-1:0]      ax, ay, bx, by, dx, dy;
  logic [DW-1:0]      diff_x, diff_y, abs_x, abs_y, len, hop_x, hop_y;
  logic               bad_pos;
  logic               unused_hi;

  // Unplaced (-1) is negative, so the range check alone covers it.
  function automatic logic off_grid(input logic [DW-1:0] c);
    return ($signed(c) < $signed(DW'(0))) || ($signed(c) > $signed(DW'(GRID_N - 1)));
  endfunction

  assign bad_pos   = off_grid(posX) || off_grid(posY);
  assign i_nxt     = edges_done + EDGE_AW'(1);
  assign unused_hi = ^{ea[DW-1:NODE_AW], eb[DW-1:NODE_AW]};

  assign diff_x = ax - bx;
  assign diff_y = ay - by;
  assign abs_x  = diff_x[DW-1] ? -diff_x : diff_x;
  assign abs_y  = diff_y[DW-1] ? -diff_y : diff_y;
  assign len    = dx + dy;
  assign hop_x  = (dx + DW'(HOP - 1)) >> HOP_LOG2;
  assign hop_y  = (dy + DW'(HOP - 1)) >> HOP_LOG2;

  assign busy = (state != IDLE);
  assign done = (state == FIN);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE: if (start) next = (n_edge != '0) ? RD_E : FIN;
      RD_E: next = W_E;
      W_E:  next = RD_A;
      RD_A: next = W_A;
      W_A:  next = bad_pos ? FIN : RD_B;
      RD_B: next = W_B;
      W_B:  next = bad_pos ? FIN : DIFF;
      DIFF: next = ACC;
      ACC:  next = (i_nxt == n_lat) ? FIN : RD_E;
      FIN:  next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Enables and addresses are registered off next-state so they sit on the port
  // exactly during RD_* and the memory answers in the following W_* cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      reE <= 1'b0; reP <= 1'b0; addrE <= '0; addrP <= '0;
      sum <= '0; sum_hop <= '0; max_len <= '0; edges_done <= '0; err <= 1'b0;
      n_lat <= '0; eb_id <= '0;
      ax <= '0; ay <= '0; bx <= '0; by <= '0; dx <= '0; dy <= '0;
    end else begin
      reE <= (next == RD_E);
      reP <= (next == RD_A) || (next == RD_B);
      if (next == RD_E) addrE <= (state == ACC) ? i_nxt : '0;
      unique case (state)
        IDLE: if (start) begin
          n_lat <= n_edge;
          sum <= '0; sum_hop <= '0; max_len <= '0; edges_done <= '0; err <= 1'b0;
        end
        W_E: begin
          addrP <= ea[NODE_AW-1:0];
          eb_id <= eb[NODE_AW-1:0];
        end
        W_A: begin
          ax <= posX; ay <= posY;
          addrP <= eb_id;
          if (bad_pos) err <= 1'b1;
        end
        W_B: begin
          bx <= posX; by <= posY;
          if (bad_pos) err <= 1'b1;
        end
        DIFF: begin
          dx <= abs_x; dy <= abs_y;
        end
        ACC: begin
          sum        <= sum + len - DW'(1);
          sum_hop    <= sum_hop + hop_x + hop_y - DW'(1);
          if ($signed(len) > $signed(max_len)) max_len <= len;
          edges_done <= i_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_placement_cost_eval.sv
// Directed + randomized bench for placement_cost_eval with an edge-list reference model.
module tb_placement_cost_eval;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_v = 1'b0;
  logic sel = 1'b0;
  logic [9:0] n_edge = '0;
  always #5 clk = ~clk;

  logic [31:0] memA [0:1023];
  logic [31:0] memB [0:1023];
  logic [31:0] posXm [0:127];
  logic [31:0] posYm [0:127];

  logic start1, start2;
  assign start1 = start_v & ~sel;
  assign start2 = start_v & sel;

  logic busy1, done1, err1, reE1, reP1;
  logic [9:0] addrE1, edges1;
  logic [6:0] addrP1;
  logic [31:0] ea1, eb1, px1, py1, sum1, hop1, max1;
  logic busy2, done2, err2, reE2, reP2;
  logic [9:0] addrE2, edges2;
  logic [6:0] addrP2;
  logic [31:0] ea2, eb2, px2, py2, sum2, hop2, max2;

  placement_cost_eval dut (
    .clk(clk), .reset(reset), .start(start1), .n_edge(n_edge),
    .busy(busy1), .done(done1), .err(err1), .reE(reE1), .addrE(addrE1),
    .ea(ea1), .eb(eb1), .reP(reP1), .addrP(addrP1), .posX(px1), .posY(py1),
    .sum(sum1), .sum_hop(hop1), .max_len(max1), .edges_done(edges1));

  placement_cost_eval #(.HOP_LOG2(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .n_edge(n_edge),
    .busy(busy2), .done(done2), .err(err2), .reE(reE2), .addrE(addrE2),
    .ea(ea2), .eb(eb2), .reP(reP2), .addrP(addrP2), .posX(px2), .posY(py2),
    .sum(sum2), .sum_hop(hop2), .max_len(max2), .edges_done(edges2));

  // Memories answer one cycle after the enable.
  always @(posedge clk) begin
    if (reE1) begin ea1 <= memA[addrE1]; eb1 <= memB[addrE1]; end
    if (reP1) begin px1 <= posXm[addrP1]; py1 <= posYm[addrP1]; end
    if (reE2) begin ea2 <= memA[addrE2]; eb2 <= memB[addrE2]; end
    if (reP2) begin px2 <= posXm[addrP2]; py2 <= posYm[addrP2]; end
  end

  int ne = 0, np = 0;
  always @(posedge clk) begin
    if (reE1) ne++;
    if (reP1) np++;
  end

  logic busy_s, done_s, err_s;
  logic [31:0] sum_s, hop_s, max_s, edges_s;
  assign busy_s  = sel ? busy2 : busy1;
  assign done_s  = sel ? done2 : done1;
  assign err_s   = sel ? err2 : err1;
  assign sum_s   = sel ? sum2 : sum1;
  assign hop_s   = sel ? hop2 : hop1;
  assign max_s   = sel ? max2 : max1;
  assign edges_s = sel ? 32'(edges2) : 32'(edges1);

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic bit bad(input int v);
    return (v < 0) || (v > 8);
  endfunction

  // Walk the edge list as the spec describes it, edge by edge.
  task automatic model(input int n, input int hop,
                       output int es, output int eh, output int em, output int ee,
                       output bit eerr, output int ecyc, output int nre, output int nrp);
    int a, b, dx, dy;
    es = 0; eh = 0; em = 0; ee = 0; eerr = 0; ecyc = 0; nre = 0; nrp = 0;
    for (int k = 0; k < n; k++) begin
      a = int'(memA[k] & 32'h7f);
      b = int'(memB[k] & 32'h7f);
      nre++; nrp++;
      if (bad(int'(posXm[a])) || bad(int'(posYm[a]))) begin eerr = 1; ecyc += 4; break; end
      nrp++;
      if (bad(int'(posXm[b])) || bad(int'(posYm[b]))) begin eerr = 1; ecyc += 6; break; end
      dx = int'(posXm[a]) - int'(posXm[b]); if (dx < 0) dx = -dx;
      dy = int'(posYm[a]) - int'(posYm[b]); if (dy < 0) dy = -dy;
      es += dx + dy - 1;
      eh += (dx + hop - 1) / hop + (dy + hop - 1) / hop - 1;
      if (dx + dy > em) em = dx + dy;
      ee++;
      ecyc += 8;
    end
    ecyc += 1;
  endtask

  task automatic run(input int n, input bit use2, input bit hold, input string tag);
    int es, eh, em, ee, ecyc, nre, nrp, ne0, np0, c, ndone, first, busy_low;
    bit eerr;
    logic busy_after;
    model(n, use2 ? 4 : 2, es, eh, em, ee, eerr, ecyc, nre, nrp);
    ne0 = ne; np0 = np;
    sel = use2; n_edge = 10'(n); start_v = 1'b1;
    @(posedge clk); #1;
    if (!hold) start_v = 1'b0;
    c = 1; ndone = 0; first = -1; busy_low = 0; busy_after = 1'bx;
    while (c < 3000 && (first < 0 || c <= first + 3)) begin
      if (done_s) begin ndone++; if (first < 0) first = c; end
      if (first < 0 && !busy_s) busy_low++;
      if (first >= 0 && c == first + 1) busy_after = busy_s;
      if (hold && c == 5) start_v = 1'b0;
      if (hold && c == 10) begin start_v = 1'b1; n_edge = 10'd1; end
      if (hold && c == 11) start_v = 1'b0;
      @(posedge clk); #1; c++;
    end
    chk({tag, "_done_cycle"}, 32'(first), 32'(ecyc));
    chk({tag, "_done_count"}, 32'(ndone), 32'd1);
    chk({tag, "_busy_during"}, 32'(busy_low), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy_after), 32'd0);
    chk({tag, "_sum"}, sum_s, 32'(es));
    chk({tag, "_sum_hop"}, hop_s, 32'(eh));
    chk({tag, "_max_len"}, max_s, 32'(em));
    chk({tag, "_edges_done"}, edges_s, 32'(ee));
    chk({tag, "_err"}, 32'(err_s), 32'(eerr));
    if (!use2) begin
      chk({tag, "_reE_pulses"}, 32'(ne - ne0), 32'(nre));
      chk({tag, "_reP_pulses"}, 32'(np - np0), 32'(nrp));
    end
    sel = 1'b0;
  endtask

  task automatic setp(input int id, input int x, input int y);
    posXm[id] = 32'(x); posYm[id] = 32'(y);
  endtask

  task automatic load3();
    memA[0] = 32'd2; memB[0] = 32'd3; setp(2, 0, 0); setp(3, 1, 0);
    memA[1] = 32'd4; memB[1] = 32'd5; setp(4, 4, 4); setp(5, 2, 2);
    memA[2] = 32'd6; memB[2] = 32'd7; setp(6, 1, 1); setp(7, 1, 6);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin memA[i] = '0; memB[i] = '0; end
    for (int i = 0; i < 128; i++) setp(i, 0, 0);
    ea1 = '0; eb1 = '0; px1 = '0; py1 = '0;
    ea2 = '0; eb2 = '0; px2 = '0; py2 = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", {27'd0, busy1, done1, err1, reE1, reP1}, 32'd0);
    chk("reset_sum", sum1 | hop1 | max1, 32'd0);
    chk("reset_cnt", 32'(edges1) | 32'(addrE1) | 32'(addrP1), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single edge (0,0)-(3,4).
    memA[0] = 32'd0; memB[0] = 32'd1; setp(0, 0, 0); setp(1, 3, 4);
    run(1, 0, 0, "one");
    chk("one_sum_const", sum1, 32'd6);
    chk("one_hop_const", hop1, 32'd3);
    chk("one_max_const", max1, 32'd7);

    load3();
    run(3, 0, 0, "three");
    chk("three_sum_const", sum1, 32'd7);
    chk("three_hop_const", hop1, 32'd3);
    chk("three_max_const", max1, 32'd5);

    run(0, 0, 0, "zero");

    // Second edge's sink is unplaced.
    memA[0] = 32'd10; memB[0] = 32'd11; setp(10, 1, 2); setp(11, 4, 0);
    memA[1] = 32'd12; memB[1] = 32'd13; setp(12, 3, 3); setp(13, -1, 3);
    run(2, 0, 0, "unplaced");
    chk("unplaced_edges_const", 32'(edges1), 32'd1);
    load3();
    run(3, 0, 0, "after_err");

    // Reset in cycle 12 of a 3-edge run.
    n_edge = 10'd3; start_v = 1'b1;
    @(posedge clk); #1;
    start_v = 1'b0;
    begin
      int c, seen;
      c = 1; seen = 0;
      while (c < 12) begin
        if (done1) seen++;
        @(posedge clk); #1; c++;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rst_mid_ctl", {27'd0, busy1, done1, err1, reE1, reP1}, 32'd0);
      chk("rst_mid_sum", sum1 | hop1 | max1 | 32'(edges1), 32'd0);
      for (int k = 0; k < 4; k++) begin
        if (done1 || busy1) seen++;
        @(posedge clk); #1;
      end
      chk("rst_mid_no_done", 32'(seen), 32'd0);
    end
    run(3, 0, 0, "post_rst");

    run(3, 0, 1, "hold_start");

    // HOP=4 build: dx=5, dy=4.
    memA[0] = 32'd20; memB[0] = 32'd21; setp(20, 0, 0); setp(21, 5, 4);
    run(1, 1, 0, "hop4");
    chk("hop4_const", hop2, 32'd2);

    for (int r = 0; r < 10; r++) begin
      int n;
      n = $urandom_range(1, 12);
      for (int i = 0; i < 128; i++) setp(i, $urandom_range(0, 8), $urandom_range(0, 8));
      for (int k = 0; k < n; k++) begin memA[k] = $urandom; memB[k] = $urandom; end
      if (r % 3 == 2) begin
        int id;
        id = int'(memB[$urandom_range(0, n - 1)] & 32'h7f);
        if (r % 2 == 0) posYm[id] = 32'd9; else posXm[id] = 32'hffffffff;
      end
      run(n, r % 4 == 3, 0, $sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
